// File: rtl/gpio_mailbox_arb.sv
// Round-robin arbiter that multiplexes NUM_REQ requesters onto one GPI word
// and runs a seq-tagged request/ack handshake with firmware over GPI/GPO.
module gpio_mailbox_arb #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                  XCLK,
  input  logic                  XRESET,
  input  logic                  XREADY,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*24-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_grant,
  output logic [NUM_REQ-1:0]    req_done,
  output logic [23:0]           rsp_data,
  output logic                  rsp_error,
  output logic                  rsp_timeout,
  output logic [31:0]           gpi,
  input  logic [31:0]           gpo,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_CLR
  } state_t;

  state_t state_q, state_d;
  logic [2:0]         id_q, id_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [3:0]         seq_q, seq_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [23:0]        cap_data_q, cap_data_d;
  logic               cap_err_q, cap_err_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [23:0]        rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic               rsp_to_q, rsp_to_d;
  logic [31:0]        gpi_q, gpi_d;

  logic               found;
  logic [2:0]         sel;
  logic [NUM_REQ-1:0] sel_oh;
  logic [NUM_REQ-1:0] id_oh;
  logic [23:0]        sel_pay;
  logic [15:0]        cnt_inc;
  logic               tmo;
  logic               ack_ok;
  int                 best;
  int                 off;
  logic               unused_gpo;

  assign unused_gpo = ^gpo[29:28];

  // Rotated priority: the valid requester with the smallest distance
  // above the pointer (mod NUM_REQ) wins.
  always_comb begin
    best    = NUM_REQ;
    off     = 0;
    sel     = '0;
    sel_oh  = '0;
    sel_pay = '0;
    id_oh   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      off = (i >= int'(ptr_q)) ? i - int'(ptr_q)
                               : i + NUM_REQ - int'(ptr_q);
      if (req_valid[i] && off < best) begin
        best      = off;
        sel       = 3'(i);
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
        sel_pay   = req_data[24*i +: 24];
      end
      id_oh[i] = (id_q == 3'(i));
    end
    found = (best < NUM_REQ);
  end

  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign tmo     = (cnt_q >= 16'(TIMEOUT - 1));
  assign ack_ok  = gpo[31] && (gpo[27:24] == seq_q);

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    ptr_d      = ptr_q;
    seq_d      = seq_q;
    cnt_d      = cnt_q;
    cap_data_d = cap_data_q;
    cap_err_d  = cap_err_q;
    grant_d    = '0;
    done_d     = '0;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    rsp_to_d   = rsp_to_q;
    gpi_d      = gpi_q;
    unique case (state_q)
      IDLE: begin
        if (XREADY && found) begin
          grant_d = sel_oh;
          id_d    = sel;
          gpi_d   = {1'b1, sel, seq_q, sel_pay};
          cnt_d   = '0;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK, WAIT_CLR: begin
        cnt_d = cnt_inc;
        if (tmo || !XREADY) begin
          done_d     = id_oh;
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          rsp_to_d   = tmo;
        end else if (state_q == WAIT_ACK && ack_ok) begin
          cap_data_d = gpo[23:0];
          cap_err_d  = gpo[30];
          gpi_d[31]  = 1'b0;
          cnt_d      = '0;
          state_d    = WAIT_CLR;
        end else if (state_q == WAIT_CLR && !gpo[31]) begin
          done_d     = id_oh;
          rsp_data_d = cap_data_q;
          rsp_err_d  = cap_err_q;
          rsp_to_d   = 1'b0;
        end
        if (done_d != '0) begin
          gpi_d   = '0;
          seq_d   = seq_q + 4'd1;
          ptr_d   = (id_q == 3'(NUM_REQ - 1)) ? 3'd0 : id_q + 3'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge XCLK or posedge XRESET) begin
    if (XRESET) begin
      state_q    <= IDLE;
      id_q       <= '0;
      ptr_q      <= '0;
      seq_q      <= '0;
      cnt_q      <= '0;
      cap_data_q <= '0;
      cap_err_q  <= 1'b0;
      grant_q    <= '0;
      done_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      rsp_to_q   <= 1'b0;
      gpi_q      <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      ptr_q      <= ptr_d;
      seq_q      <= seq_d;
      cnt_q      <= cnt_d;
      cap_data_q <= cap_data_d;
      cap_err_q  <= cap_err_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      rsp_to_q   <= rsp_to_d;
      gpi_q      <= gpi_d;
    end
  end

  assign req_grant   = grant_q;
  assign req_done    = done_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_error   = rsp_err_q;
  assign rsp_timeout = rsp_to_q;
  assign gpi         = gpi_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_gpio_mailbox_arb.sv
// Directed bench for gpio_mailbox_arb (NUM_REQ=4, TIMEOUT=8).
module tb_gpio_mailbox_arb;

  logic        XCLK = 1'b0;
  logic        XRESET = 1'b1;
  logic        XREADY = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [95:0] req_data;
  logic [3:0]  req_grant;
  logic [3:0]  req_done;
  logic [23:0] rsp_data;
  logic        rsp_error;
  logic        rsp_timeout;
  logic [31:0] gpi;
  logic [31:0] gpo = '0;
  logic        busy;
  logic [23:0] pay [4];

  int n_cmp = 0;
  int n_err = 0;

  assign req_data = {pay[3], pay[2], pay[1], pay[0]};

  gpio_mailbox_arb #(.NUM_REQ(4), .TIMEOUT(8)) dut (
    .XCLK(XCLK), .XRESET(XRESET), .XREADY(XREADY),
    .req_valid(req_valid), .req_data(req_data),
    .req_grant(req_grant), .req_done(req_done),
    .rsp_data(rsp_data), .rsp_error(rsp_error),
    .rsp_timeout(rsp_timeout), .gpi(gpi), .gpo(gpo),
    .busy(busy)
  );

  always #5 XCLK = ~XCLK;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge XCLK);
    #1;
  endtask

  task automatic do_reset();
    XRESET = 1'b1;
    tick();
    tick();
    XRESET = 1'b0;
    gpo = '0;
  endtask

  // One full good transaction; requester id must already be valid.
  task automatic xact(input int id, input int sq,
                      input logic [23:0] rsp, input logic err,
                      input bit keep);
    tick();
    check("grant", 32'(req_grant), 32'(1 << id));
    check("gpi_req", gpi, {1'b1, 3'(id), 4'(sq), pay[id]});
    if (!keep) req_valid[id] = 1'b0;
    gpo = {1'b1, err, 2'b00, 4'(sq), rsp};
    tick();
    check("gpi_ackd", gpi, {1'b0, 3'(id), 4'(sq), pay[id]});
    gpo = '0;
    tick();
    check("done", 32'(req_done), 32'(1 << id));
    check("rsp_data", 32'(rsp_data), 32'(rsp));
    check("rsp_error", 32'(rsp_error), 32'(err));
    check("rsp_timeout", 32'(rsp_timeout), 32'd0);
    check("gpi_idle", gpi, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pay[0] = 24'hA00000;
    pay[1] = 24'h345678;
    pay[2] = 24'hC22222;
    pay[3] = 24'hD33333;
    #1;
    check("rst_gpi", gpi, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    do_reset();
    check("rst_grant", 32'(req_grant), 32'd0);
    check("rst_done", 32'(req_done), 32'd0);
    check("rst_rsp", {rsp_error, rsp_timeout, 6'd0, rsp_data}, 32'd0);

    // Single request, hand-computed words
    XREADY = 1'b1;
    req_valid = 4'b0010;
    tick();
    check("t1_grant", 32'(req_grant), 32'h2);
    check("t1_gpi", gpi, 32'h90345678);
    check("t1_busy", 32'(busy), 32'd1);
    req_valid = '0;
    gpo = 32'h8000ABCD;
    tick();
    check("t1_grant_pulse", 32'(req_grant), 32'd0);
    check("t1_gpi_clr", gpi, 32'h10345678);
    gpo = '0;
    tick();
    check("t1_done", 32'(req_done), 32'h2);
    check("t1_rsp", 32'(rsp_data), 32'h00ABCD);
    check("t1_err", 32'(rsp_error), 32'd0);
    check("t1_gpi0", gpi, 32'd0);
    check("t1_busy0", 32'(busy), 32'd0);
    tick();
    check("t1_done_pulse", 32'(req_done), 32'd0);
    check("t1_rsp_held", 32'(rsp_data), 32'h00ABCD);

    // Advance seq to 3 with requesters 2 and 3
    req_valid = 4'b0100;
    xact(2, 1, 24'h000111, 1'b0, 1'b0);
    req_valid = 4'b1000;
    xact(3, 2, 24'h000222, 1'b0, 1'b0);

    // Wrong-seq ack ignored, then error ack
    req_valid = 4'b0001;
    tick();
    check("ws_grant", 32'(req_grant), 32'h1);
    check("ws_gpi", gpi, 32'h83A00000);
    req_valid = '0;
    gpo = 32'h85111111;
    tick();
    check("ws_ignored1", gpi, 32'h83A00000);
    tick();
    check("ws_ignored2", gpi, 32'h83A00000);
    check("ws_nodone", 32'(req_done), 32'd0);
    gpo = 32'hC3222222;
    tick();
    check("ws_accept", gpi, 32'h03A00000);
    gpo = '0;
    tick();
    check("ws_done", 32'(req_done), 32'h1);
    check("ws_rsp", 32'(rsp_data), 32'h222222);
    check("ws_err", 32'(rsp_error), 32'd1);
    check("ws_to", 32'(rsp_timeout), 32'd0);

    // Round-robin from fresh reset
    do_reset();
    XREADY = 1'b1;
    req_valid = 4'b1111;
    for (int t = 0; t < 5; t++)
      xact(t % 4, t, 24'h000500 + 24'(t), 1'b0, 1'b1);
    req_valid = '0;

    // Timeout: silent firmware, seq=5, pointer at 1
    req_valid = 4'b0010;
    tick();
    check("to_grant", 32'(req_grant), 32'h2);
    check("to_gpi", gpi, 32'h95345678);
    req_valid = '0;
    for (int k = 1; k < 8; k++) begin
      tick();
      check("to_early", {31'd0, req_done[1]}, 32'd0);
    end
    tick();
    check("to_done", 32'(req_done), 32'h2);
    check("to_err", 32'(rsp_error), 32'd1);
    check("to_flag", 32'(rsp_timeout), 32'd1);
    check("to_rsp", 32'(rsp_data), 32'd0);
    check("to_gpi", gpi, 32'd0);
    check("to_busy", 32'(busy), 32'd0);

    // XREADY drop in WAIT_CLR, seq=6, pointer at 2
    req_valid = 4'b0100;
    tick();
    check("xr_grant", 32'(req_grant), 32'h4);
    req_valid = '0;
    gpo = 32'h86000777;
    tick();
    check("xr_ack", gpi, 32'h26C22222);
    XREADY = 1'b0;
    tick();
    check("xr_done", 32'(req_done), 32'h4);
    check("xr_err", 32'(rsp_error), 32'd1);
    check("xr_to", 32'(rsp_timeout), 32'd0);
    check("xr_rsp", 32'(rsp_data), 32'd0);
    gpo = '0;
    req_valid = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("xr_hold", {27'd0, busy, req_grant}, 32'd0);
    end
    XREADY = 1'b1;
    tick();
    check("xr_regrant", 32'(req_grant), 32'h1);
    check("xr_gpi", gpi, 32'h87A00000);
    req_valid = '0;

    // Async reset during WAIT_ACK
    tick();
    XRESET = 1'b1;
    #1;
    check("ar_gpi", gpi, 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_nodone", 32'(req_done), 32'd0);
    tick();
    XRESET = 1'b0;
    req_valid = 4'b1010;
    tick();
    check("ar_nodone2", 32'(req_done), 32'd0);
    check("ar_grant", 32'(req_grant), 32'h2);
    check("ar_gpi_seq0", gpi, 32'h90345678);
    req_valid = '0;
    gpo = 32'h80000042;
    tick();
    gpo = '0;
    tick();
    check("ar_done", 32'(req_done), 32'h2);
    check("ar_rsp", 32'(rsp_data), 32'h42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
